// File: rtl/rx8b10b_deserialize_if.sv
// Line-side and symbol-side signals of the 8b10b receive deserializer.
// RX8B10B_REALIGN_CNT_EN adds the realign_cnt_o loss-of-lock counter.
interface rx8b10b_deserialize_if;
  logic [1:0]  serial_i;
  logic        ddr_i;
  logic        in_valid_i;
  logic [19:0] parallel_o;
  logic        valid_o;
  logic        locked_o;
  logic        realign_o;
`ifdef RX8B10B_REALIGN_CNT_EN
  logic [7:0]  realign_cnt_o;

  modport slave  (input serial_i, ddr_i, in_valid_i,
                  output parallel_o, valid_o, locked_o, realign_o, realign_cnt_o);
  modport master (output serial_i, ddr_i, in_valid_i,
                  input parallel_o, valid_o, locked_o, realign_o, realign_cnt_o);
`else
  modport slave  (input serial_i, ddr_i, in_valid_i,
                  output parallel_o, valid_o, locked_o, realign_o);
  modport master (output serial_i, ddr_i, in_valid_i,
                  input parallel_o, valid_o, locked_o, realign_o);
`endif
endinterface

// File: rtl/rx8b10b_deserialize.sv
// Comma-aligning 1/2-bit-per-cycle deserializer producing 20-bit symbol pairs.
// RX8B10B_REALIGN_CNT_EN enables the saturating LOCKED->HUNT counter.
module rx8b10b_deserialize #(
  parameter int unsigned LOSS_CNT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  rx8b10b_deserialize_if.slave  bus
);
  localparam logic [9:0] COMMA_N = 10'h0FA;
  localparam logic [9:0] COMMA_P = 10'h305;
  localparam logic [3:0] LOSS    = 4'(LOSS_CNT);

  typedef enum logic {HUNT, LOCKED} state_e;

  state_e      state_q, state_d;
  logic [20:0] hist_q, hist_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [3:0]  miss_q, miss_d;
  logic [19:0] parallel_q;
  logic        valid_q, locked_q, realign_q;
  logic        cap, cap_early, realign_d, bit_v, comma;
`ifdef RX8B10B_REALIGN_CNT_EN
  logic        lost;
  logic [7:0]  realign_cnt_q;
`endif

  // Bits are walked in arrival order so a DDR cycle behaves like two SDR cycles.
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    bitcnt_d  = bitcnt_q;
    miss_d    = miss_q;
    cap       = 1'b0;
    cap_early = 1'b0;
    realign_d = 1'b0;
    bit_v     = 1'b0;
    comma     = 1'b0;
`ifdef RX8B10B_REALIGN_CNT_EN
    lost      = 1'b0;
`endif
    if (bus.in_valid_i) begin
      for (int i = 0; i < 2; i++) begin
        if (i == 0 || bus.ddr_i) begin
          bit_v  = (i == 0) ? bus.serial_i[1] : bus.serial_i[0];
          hist_d = {hist_d[19:0], bit_v};
          comma  = (hist_d[9:0] == COMMA_N) || (hist_d[9:0] == COMMA_P);
          if (state_d == HUNT) begin
            if (comma) begin
              state_d   = LOCKED;
              bitcnt_d  = 5'd10;
              realign_d = 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_d + 5'd1;
            if (comma) miss_d = (bitcnt_d == 5'd10) ? 4'd0 : miss_d + 4'd1;
            if (miss_d == LOSS) begin
              state_d = HUNT;
              miss_d  = 4'd0;
`ifdef RX8B10B_REALIGN_CNT_EN
              lost    = 1'b1;
`endif
            end else if (bitcnt_d == 5'd20) begin
              bitcnt_d  = 5'd0;
              cap       = 1'b1;
              cap_early = (i == 0) && bus.ddr_i;
            end
          end
        end
      end
    end
  end

  // A pair closed on the first DDR bit sits one position higher by cycle end.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= HUNT;
      hist_q     <= '0;
      bitcnt_q   <= '0;
      miss_q     <= '0;
      parallel_q <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      realign_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      bitcnt_q  <= bitcnt_d;
      miss_q    <= miss_d;
      valid_q   <= cap;
      locked_q  <= (state_d == LOCKED);
      realign_q <= realign_d;
      if (cap) parallel_q <= cap_early ? hist_d[20:1] : hist_d[19:0];
    end
  end

`ifdef RX8B10B_REALIGN_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                            realign_cnt_q <= '0;
    else if (lost && realign_cnt_q != '1) realign_cnt_q <= realign_cnt_q + 8'd1;
  end
  assign bus.realign_cnt_o = realign_cnt_q;
`endif

  assign bus.parallel_o = parallel_q;
  assign bus.valid_o    = valid_q;
  assign bus.locked_o   = locked_q;
  assign bus.realign_o  = realign_q;
endmodule

// File: tb/tb_rx8b10b_deserialize.sv
// Self-checking bench: directed scenarios plus random traffic against a bit-stream model.
module tb_rx8b10b_deserialize;
  localparam int LOSS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rx8b10b_deserialize_if bus();
  rx8b10b_deserialize #(.LOSS_CNT(LOSS)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Model: every received bit kept with its absolute index; pairs located by modulo.
  logic        bits[$];
  logic        m_locked, m_vld, m_rea, armed;
  int          align, miss, lossn;
  logic        exp_valid, exp_locked, exp_realign;
  logic [19:0] exp_par;

  function automatic logic gb(int idx);
    return (idx < 0) ? 1'b0 : bits[idx];
  endfunction

  task automatic model_bit(input logic b);
    int n, off;
    logic [9:0] w;
    logic [19:0] p;
    bits.push_back(b);
    n = bits.size();
    w = '0;
    for (int k = 0; k < 10; k++) w = {w[8:0], gb(n - 10 + k)};
    if (!m_locked) begin
      if (w == 10'h0FA || w == 10'h305) begin
        m_locked = 1'b1; align = n - 10; m_rea = 1'b1;
      end
    end else begin
      off = (n - align) % 20;
      if (w == 10'h0FA || w == 10'h305) begin
        if (off == 10) miss = 0; else miss++;
        if (miss == LOSS) begin
          m_locked = 1'b0; miss = 0;
          if (lossn < 255) lossn++;
          return;
        end
      end
      if (off == 0) begin
        p = '0;
        for (int k = 0; k < 20; k++) p = {p[18:0], gb(n - 20 + k)};
        exp_par = p; m_vld = 1'b1;
      end
    end
  endtask

  initial begin
    armed = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        bits.delete();
        m_locked = 1'b0; miss = 0; lossn = 0; align = 0;
        exp_valid = 1'b0; exp_locked = 1'b0; exp_realign = 1'b0; exp_par = '0;
        armed = 1'b1;
      end else if (bus.in_valid_i) begin
        m_vld = 1'b0; m_rea = 1'b0;
        model_bit(bus.serial_i[1]);
        if (bus.ddr_i) model_bit(bus.serial_i[0]);
        exp_valid = m_vld; exp_realign = m_rea; exp_locked = m_locked;
      end else begin
        exp_valid = 1'b0; exp_realign = 1'b0;
      end
    end
  end

  logic [19:0] got[$];
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("valid_o", bus.valid_o, exp_valid);
        chk("locked_o", bus.locked_o, exp_locked);
        chk("realign_o", bus.realign_o, exp_realign);
        chk("parallel_o", bus.parallel_o, exp_par);
`ifdef RX8B10B_REALIGN_CNT_EN
        chk("realign_cnt_o", bus.realign_cnt_o, lossn);
`endif
        if (bus.valid_o === 1'b1) got.push_back(bus.parallel_o);
      end
    end
  end

  // Stimulus helpers: inputs change right after a negedge, outputs read at the next one.
  task automatic drive(input logic iv, input logic d, input logic [1:0] s);
    bus.in_valid_i = iv; bus.ddr_i = d; bus.serial_i = s;
    @(negedge clk);
  endtask

  task automatic sbits(input logic [19:0] v, input int nb);
    for (int k = nb - 1; k >= 0; k--) drive(1'b1, 1'b0, {v[k], 1'b0});
  endtask

  logic tx[$];
  task automatic push_bits(input logic [19:0] v, input int nb);
    for (int k = nb - 1; k >= 0; k--) tx.push_back(v[k]);
  endtask

  // mode 0: SDR, 1: DDR, 2: random ddr_i with random in_valid_i gaps
  task automatic feed(input int mode);
    logic iv, d;
    logic [1:0] s;
    while (tx.size() > 0) begin
      iv = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      d  = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      s  = 2'($urandom);
      if (iv) begin
        s[1] = tx.pop_front();
        if (d) s[0] = (tx.size() > 0) ? tx.pop_front() : 1'b0;
      end
      drive(iv, d, s);
    end
    drive(1'b0, 1'b0, 2'b00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00);
    chk("reset valid_o", bus.valid_o, 0);
    chk("reset locked_o", bus.locked_o, 0);
    chk("reset realign_o", bus.realign_o, 0);
    chk("reset parallel_o", bus.parallel_o, 0);
    rst = 1'b0;
    got.delete();
  endtask

  logic [9:0]  dset[4];
  logic [19:0] exp_pairs[$];
  logic [9:0]  dv;

  initial begin
    dset[0] = 10'h2AA; dset[1] = 10'h155; dset[2] = 10'h3C3; dset[3] = 10'h0F0;
    rst = 1'b1; bus.in_valid_i = 1'b0; bus.ddr_i = 1'b0; bus.serial_i = 2'b00;
    @(negedge clk);
    do_reset();

    // SDR lock on RD- comma
    sbits(20'h0, 3);
    sbits(20'h0FA, 10);
    chk("sdr locked", bus.locked_o, 1);
    chk("sdr realign", bus.realign_o, 1);
    sbits(20'h2AA, 10);
    chk("sdr valid1", bus.valid_o, 1);
    chk("sdr pair1", bus.parallel_o, 20'h3EAAA);
    sbits(20'h0FA, 10);
    chk("sdr realign quiet", bus.realign_o, 0);
    sbits(20'h155, 10);
    chk("sdr valid2", bus.valid_o, 1);
    chk("sdr pair2", bus.parallel_o, 20'h3E955);

    // DDR, pair boundary on the first bit of a cycle
    do_reset();
    push_bits(20'h0, 1);
    push_bits(20'h3EAAA, 20);
    push_bits(20'h3E955, 20);
    push_bits(20'h0, 1);
    feed(1);
    chk("ddr count", got.size(), 2);
    if (got.size() == 2) begin
      chk("ddr pair1", got[0], 20'h3EAAA);
      chk("ddr pair2", got[1], 20'h3E955);
    end

    // in_valid_i gaps with mixed ddr_i
    do_reset();
    exp_pairs.delete();
    push_bits(20'h0, 3);
    for (int p = 0; p < 8; p++) begin
      dv = dset[$urandom_range(0, 3)];
      exp_pairs.push_back({10'h0FA, dv});
      push_bits({10'h0FA, dv}, 20);
    end
    feed(2);
    chk("gap count", got.size(), exp_pairs.size());
    for (int k = 0; k < exp_pairs.size() && k < got.size(); k++)
      chk("gap pair", got[k], exp_pairs[k]);

    // loss of lock after LOSS misaligned commas, then relock
    do_reset();
    sbits(20'h0, 3);
    sbits(20'h3EAAA, 20);
    sbits(20'h3E955, 20);
    sbits(20'h0, 3);
    for (int p = 0; p < 3; p++) sbits(20'h3EAAA, 20);
    chk("loss still locked", bus.locked_o, 1);
    sbits(20'h3E955, 20);
    chk("loss unlocked", bus.locked_o, 0);
    sbits(20'h0FA, 10);
    chk("relock locked", bus.locked_o, 1);
    chk("relock realign", bus.realign_o, 1);
`ifdef RX8B10B_REALIGN_CNT_EN
    chk("realign_cnt", bus.realign_cnt_o, 1);
`endif
    sbits(20'h155, 10);

    // RD+ comma, then reset in the middle of a pair
    do_reset();
    sbits(20'h0, 2);
    sbits(20'h305, 10);
    chk("rdp locked", bus.locked_o, 1);
    sbits(20'h2AA, 10);
    chk("rdp pair", bus.parallel_o, 20'hC16AA);
    sbits(20'h1F, 7);
    do_reset();
    drive(1'b0, 1'b0, 2'b00);
    chk("post reset no valid", bus.valid_o, 0);
    sbits(20'h0FA, 10);
    chk("post reset relock", bus.locked_o, 1);
    chk("post reset realign", bus.realign_o, 1);

    // random traffic with occasional slips
    for (int r = 0; r < 3; r++) begin
      do_reset();
      push_bits(20'h0, 3);
      for (int p = 0; p < 50; p++) begin
        if ($urandom_range(0, 9) == 0) push_bits(20'($urandom), $urandom_range(1, 5));
        push_bits({($urandom_range(0, 1) != 0) ? 10'h305 : 10'h0FA, 10'($urandom)}, 20);
      end
      feed(2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
